// File: rtl/timer_arbiter_pkg.sv
// Shared definitions for the timer arbiter: FSM state encoding, default sizing
// and the delay-length helper.
package timer_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CNT_W   = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Full-width product so large frequencies and delays never wrap.
  function automatic logic [63:0] delay_cycles(input logic [31:0] freq,
                                               input logic [31:0] secs);
    return {32'd0, freq} * {32'd0, secs};
  endfunction

endpackage

// File: rtl/timer_down_counter.sv
// Loadable down-counter with a zero flag; the arbiter owns all sequencing.
module timer_down_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  input  logic             clear,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/timer_arbiter.sv
// Shared delay timer arbitrated among NUM_REQ requesters.
// Define TIMER_ARBITER_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           clock_frequency,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [32*NUM_REQ-1:0] time_in_seconds,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    timer_done,
  output logic                  busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  logic             owner_req;
  logic [31:0]      tsel;
  logic [63:0]      product;
  logic             cnt_zero;
  logic             grab, abort, cnt_load, cnt_dec, finish;

  assign owner_req = |(req & grant);
  assign tsel      = time_in_seconds[32*owner +: 32];
  assign product   = delay_cycles(clock_frequency, tsel);

`ifdef TIMER_ARBITER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr;

  // Walk backwards so the last hit is the first requester at or after ptr.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (finish || abort) begin
      ptr <= IDX_W'((int'(owner) + 1) % NUM_REQ);
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (win_vld) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (!owner_req)           state_nxt = ST_IDLE;
        else if (product == 64'd0) state_nxt = ST_DONE;
        else                      state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        if (!owner_req)    state_nxt = ST_IDLE;
        else if (cnt_zero) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // An owner dropping req beats expiry in the same cycle.
  always_comb begin
    busy     = (state != ST_IDLE);
    grab     = (state == ST_IDLE) && win_vld;
    abort    = ((state == ST_LOAD) || (state == ST_COUNT)) && !owner_req;
    cnt_load = (state == ST_LOAD) && owner_req && (product != 64'd0);
    cnt_dec  = (state == ST_COUNT) && owner_req && !cnt_zero;
    finish   = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= '0;
      owner      <= '0;
      timer_done <= '0;
    end else begin
      timer_done <= '0;
      if (grab) begin
        grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
        owner <= win_idx;
      end else if (abort || finish) begin
        grant <= '0;
      end
      if (finish) begin
        timer_done <= grant;
      end
    end
  end

  timer_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (CNT_W'(product - 64'd1)),
    .dec        (cnt_dec),
    .clear      (abort),
    .zero       (cnt_zero)
  );

endmodule

// File: tb/tb_timer_arbiter.sv
// Randomised scoreboard bench for timer_arbiter: a transaction-level model
// predicts winner and expiry cycle; a monitor matches every timer_done pulse.
module tb_timer_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     freq;
  logic [N-1:0]    req;
  logic [32*N-1:0] tis;
  logic [N-1:0]    grant;
  logic [N-1:0]    timer_done;
  logic            busy;

  always #5 clk = ~clk;

  timer_arbiter #(.NUM_REQ(N), .CNT_W(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .clock_frequency (freq),
    .req             (req),
    .time_in_seconds (tis),
    .grant           (grant),
    .timer_done      (timer_done),
    .busy            (busy)
  );

  typedef struct {
    logic [N-1:0] mask;
    int           at;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   ptr_m  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] p, input int ptr);
`ifdef TIMER_ARBITER_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++) if (p[(ptr + k) % N]) return (ptr + k) % N;
`else
    for (int i = 0; i < N; i++) if (p[i]) return i;
`endif
    return 0;
  endfunction

  function automatic logic [63:0] model_p(input int w);
    logic [31:0] t;
    t = tis[32*w +: 32];
    return 64'(freq) * 64'(t);
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_t(input int i, input logic [31:0] v);
    tis[32*i +: 32] = v;
  endtask

  task automatic randomize_inputs();
    freq = $urandom_range(0, 7);
    for (int i = 0; i < N; i++) set_t(i, $urandom_range(0, 5));
  endtask

  // Serve a request pattern to completion; each winner drops req after its pulse.
  task automatic serve(input logic [N-1:0] pat, input bit scramble);
    logic [N-1:0] p;
    logic [63:0]  pp;
    logic [N-1:0] oh;
    int w, e, done_at;
    p   = pat;
    req = p;
    while (p != '0) begin
      w       = pick(p, ptr_m);
      e       = cyc + 1;
      pp      = model_p(w);
      done_at = e + int'(pp) + 2;
      oh      = '0;
      oh[w]   = 1'b1;
      q.push_back('{mask: oh, at: done_at});
      wait_cyc(e);
      check("grant_owner", 64'(grant), 64'(oh));
      check("busy_active", 64'(busy), 64'd1);
      if (scramble) begin
        wait_cyc(e + 1);
        randomize_inputs();
      end
      wait_cyc(done_at);
      check("busy_after_done", 64'(busy), 64'd0);
      check("grant_after_done", 64'(grant), 64'd0);
      p[w]  = 1'b0;
      req   = p;
      ptr_m = (w + 1) % N;
    end
  endtask

  // Owner w drops req d cycles after the sampling edge (0 = during LOAD).
  task automatic abort_txn(input int w, input int d);
    logic [N-1:0] oh;
    int e;
    oh    = '0;
    oh[w] = 1'b1;
    req   = oh;
    e     = cyc + 1;
    wait_cyc(e);
    check("abort_grant", 64'(grant), 64'(oh));
    wait_cyc(e + d);
    req = '0;
    wait_cyc(e + d + 1);
    check("abort_grant_clr", 64'(grant), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);
    ptr_m = (w + 1) % N;
    wait_cyc(e + d + 4);
  endtask

  always @(negedge clk) begin
    if (timer_done !== '0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual %b required none (cycle %0d)", timer_done, cyc);
      end else begin
        exp_t x;
        x = q.pop_front();
        check("done_mask", 64'(timer_done), 64'(x.mask));
        check("done_cycle", 64'(cyc), 64'(x.at));
      end
    end
  end

  initial begin
    int e, w;
    logic [63:0] pp;
    reset = 1'b1;
    req   = '0;
    freq  = '0;
    tis   = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_done", 64'(timer_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    freq = 32'd10; set_t(0, 32'd3);
    serve(4'b0001, 1'b0);

    freq = 32'd4; set_t(1, 32'd1); set_t(2, 32'd1);
    serve(4'b0110, 1'b0);
    serve(4'b0110, 1'b0);

    set_t(3, 32'd0);
    serve(4'b1000, 1'b0);

    freq = 32'd100; set_t(0, 32'd1);
    abort_txn(0, 50);
    freq = 32'd3;
    abort_txn(0, 3);
    abort_txn(2, 0);

    freq = 32'hFFFF_FFFF; set_t(0, 32'd2);
    req = 4'b0001;
    e   = cyc + 1;
    wait_cyc(e + 1);
    check("wide_load", dut.u_cnt.count, 64'h1_FFFF_FFFD);
    req = '0;
    wait_cyc(e + 2);
    check("wide_abort_grant", 64'(grant), 64'd0);
    ptr_m = 1;
    wait_cyc(e + 4);

    freq = 32'd255; set_t(1, 32'd1);
    req = 4'b0010;
    e   = cyc + 1;
    wait_cyc(e + 50);
    #2 reset = 1'b1;
    req = '0;
    #1;
    check("arst_grant", 64'(grant), 64'd0);
    check("arst_done", 64'(timer_done), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_count", dut.u_cnt.count, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ptr_m = 0;
    repeat (300) @(negedge clk);
    check("arst_no_pending", 64'(q.size()), 64'd0);

    for (int n = 0; n < 30; n++) begin
      randomize_inputs();
      if ($urandom_range(0, 3) == 0) begin
        w  = $urandom_range(0, N - 1);
        pp = model_p(w);
        abort_txn(w, $urandom_range(0, int'(pp)));
      end else begin
        serve(N'($urandom_range(1, (1 << N) - 1)), 1'($urandom_range(0, 1)));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the delay timer (2..8).
REQ-002 SHALL have parameter CNT_W, default 64, width of the internal cycle down-counter.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clock_frequency  input  32  clk cycles per second, unsigned.
REQ-006 SHALL have port req  input  NUM_REQ  level request per requester, held until done or abort.
REQ-007 SHALL have port time_in_seconds  input  32*NUM_REQ  per-requester delay; requester i uses bits [32*i+31:32*i].
REQ-008 SHALL have port grant  output  NUM_REQ  one-hot owner of the timer, all-zero when idle.
REQ-009 SHALL have port timer_done  output  NUM_REQ  one-hot, one-cycle expiry pulse to the owner.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, COUNT, DONE.
REQ-012 IDLE: SHALL pick a winner when req nonzero, register it in grant, move to LOAD; otherwise stay.
REQ-013 LOAD: SHALL compute P = clock_frequency * time_in_seconds[winner] as a full 64-bit unsigned product, no truncation.
REQ-014 LOAD: SHALL go to DONE when P == 0, else load counter with P-1 and go to COUNT.
REQ-015 COUNT: SHALL decrement the counter once per cycle; at counter == 0 SHALL go to DONE.
REQ-016 DONE: SHALL assert timer_done[winner] for exactly one cycle, clear grant, return to IDLE.
REQ-017 Latency: timer_done SHALL be high in the cycle following edge E+P+2, with E the IDLE edge that sampled req (P=0 gives E+2).
REQ-018 time_in_seconds and clock_frequency SHALL be sampled only in LOAD; later changes have no effect on the active delay.
REQ-019 Abort: owner deasserting req in LOAD or COUNT SHALL return FSM to IDLE next edge, clear grant, emit no timer_done.
REQ-020 Abort at counter == 0 in the same cycle SHALL win: no timer_done.
REQ-021 No arbitration in LOAD, COUNT or DONE; new requests wait until IDLE.
REQ-022 Requester keeping req high after timer_done SHALL be re-arbitrated as a new request.
REQ-023 grant SHALL be stable and one-hot from LOAD through DONE.

Reset
REQ-024 reset high SHALL asynchronously force state IDLE, grant 0, timer_done 0, busy 0, counter 0, priority pointer 0.
REQ-025 reset mid-COUNT SHALL discard the delay; no timer_done after release.

Configuration
REQ-026 With TIMER_ARBITER_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin: search starts at index after last winner, pointer updates in DONE or abort.
REQ-027 Without TIMER_ARBITER_ROUND_ROBIN_EN, arbitration SHALL be fixed priority, lowest index wins; no pointer register exists.

Structure
REQ-028 Shared package SHALL hold state encoding constants (IDLE/LOAD/COUNT/DONE) and default NUM_REQ/CNT_W constants.
REQ-029 Counter (load, decrement, zero flag) SHALL be a sub-module named timer_down_counter; arbitration and FSM stay in timer_arbiter.

Verification
REQ-030 clock_frequency=10, req=4'b0001, time_in_seconds[0]=3 -> grant=0001, timer_done[0] pulses once, 32 cycles after sampling edge.
REQ-031 req=4'b0110 simultaneously, time 1, freq 4 -> fixed priority: req1 served then req2; round-robin after req1 win: req2 before req1 on re-request.
REQ-032 time_in_seconds[3]=0, req[3] only -> timer_done[3] high 2 cycles after sampling edge, busy low next cycle.
REQ-033 freq 100, time 1, req[0] drops at cycle 50 of COUNT -> no timer_done, grant 0 next cycle, IDLE.
REQ-034 reset asserted mid-COUNT (freq 255, time 1) -> outputs 0 immediately without clock; after release no timer_done.
REQ-035 freq 32'hFFFF_FFFF, time 2 -> P computed without overflow (counter loads 0x1_FFFF_FFFD); check loaded value, then abort.
